// File: rtl/cndm_msi_irq_ctrl.sv
// MSI interrupt scheduler for the UltraScale PCIe hard IP (function 0).
// Folds per-vector requests into pending bits, applies the host mask, and issues one MSI at a time in round-robin order.
module cndm_msi_irq_ctrl #(
  parameter int unsigned IRQ_CNT     = 32,
  parameter int unsigned RETRY_DELAY = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IRQ_CNT-1:0] irq_req,
  input  logic [3:0]         cfg_interrupt_msi_enable,
  input  logic [11:0]        cfg_interrupt_msi_mmenable,
  input  logic               cfg_interrupt_msi_mask_update,
  input  logic [31:0]        cfg_interrupt_msi_data,
  output logic [1:0]         cfg_interrupt_msi_select,
  output logic [31:0]        cfg_interrupt_msi_int,
  input  logic               cfg_interrupt_msi_sent,
  input  logic               cfg_interrupt_msi_fail,
  output logic [31:0]        cfg_interrupt_msi_pending_status,
  output logic               cfg_interrupt_msi_pending_status_data_enable,
  output logic [1:0]         cfg_interrupt_msi_pending_status_function_num,
  output logic               stat_sent,
  output logic               stat_fail
);

  localparam int unsigned VW      = (IRQ_CNT > 1) ? $clog2(IRQ_CNT) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT > RETRY_DELAY) ? TIMEOUT : RETRY_DELAY;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BACKOFF
  } state_t;

  state_t             state_q, state_d;
  logic [IRQ_CNT-1:0] pending_q, pending_d;
  logic [IRQ_CNT-1:0] mask_q, mask_d;
  logic [VW-1:0]      rr_q, rr_d;
  logic [VW-1:0]      vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        msi_int_q, msi_int_d;
  logic               stat_sent_q, stat_sent_d;
  logic               stat_fail_q, stat_fail_d;
  logic               data_en_q, data_en_d;

  int unsigned          nvec;
  int unsigned          sum;
  logic [IRQ_CNT-1:0]   vec_en;
  logic [IRQ_CNT-1:0]   req_fold;
  logic [IRQ_CNT-1:0]   eligible;
  logic [2*IRQ_CNT-1:0] rot;
  logic                 grant_vld;
  logic [VW-1:0]        grant_idx;
  logic [IRQ_CNT-1:0]   grant_oh;
  logic [IRQ_CNT-1:0]   vec_oh;
  logic [IRQ_CNT-1:0]   pend_clr;
  logic [IRQ_CNT-1:0]   pend_retry;
  logic                 issue;
  logic                 unused_bits;

  always_comb begin
    unused_bits = ^{cfg_interrupt_msi_enable[3:1], cfg_interrupt_msi_mmenable[11:3],
                    cfg_interrupt_msi_data};
  end

  // nvec is a power of two whenever it is below IRQ_CNT, so folding is an OR of nvec-wide slices.
  always_comb begin
    nvec = 32'd1 << cfg_interrupt_msi_mmenable[2:0];
    if (nvec > IRQ_CNT) begin
      nvec = IRQ_CNT;
    end
    vec_en = '0;
    for (int unsigned v = 0; v < IRQ_CNT; v++) begin
      vec_en[v] = (v < nvec);
    end
    req_fold = '0;
    for (int unsigned k = 0; k < IRQ_CNT; k++) begin
      if (k * nvec < IRQ_CNT) begin
        req_fold = req_fold | ((irq_req >> (k * nvec)) & vec_en);
      end
    end
  end

  always_comb begin
    eligible  = pending_q & ~mask_q & vec_en & {IRQ_CNT{cfg_interrupt_msi_enable[0]}};
    rot       = {eligible, eligible} >> rr_q;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int unsigned j = 0; j < IRQ_CNT; j++) begin
      if (!grant_vld && rot[j]) begin
        grant_vld = 1'b1;
        sum       = 32'(rr_q) + j;
        if (sum >= IRQ_CNT) begin
          sum = sum - IRQ_CNT;
        end
        grant_idx = VW'(sum);
      end
    end
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
    vec_oh              = '0;
    vec_oh[vec_q]       = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    msi_int_d   = '0;
    stat_sent_d = 1'b0;
    stat_fail_d = 1'b0;
    pend_clr    = '0;
    pend_retry  = '0;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        issue = grant_vld;
      end
      ST_WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          stat_sent_d = 1'b1;
          rr_d        = (vec_q == VW'(IRQ_CNT - 1)) ? '0 : vec_q + 1'b1;
          state_d     = ST_IDLE;
        end else if (cfg_interrupt_msi_fail || cnt_q == CNT_W'(TIMEOUT - 1)) begin
          stat_fail_d = 1'b1;
          pend_retry  = vec_oh;
          cnt_d       = '0;
          state_d     = ST_BACKOFF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BACKOFF: begin
        // The last backoff cycle arbitrates directly so the retry lands RETRY_DELAY+1 cycles after the failure.
        if (cnt_q == CNT_W'(RETRY_DELAY - 1)) begin
          issue   = grant_vld;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (issue) begin
      msi_int_d[IRQ_CNT-1:0] = grant_oh;
      pend_clr               = grant_oh;
      vec_d                  = grant_idx;
      cnt_d                  = '0;
      state_d                = ST_WAIT;
    end
  end

  // New requests are OR-ed in last so a request coinciding with the issue of the same vector keeps it pending.
  always_comb begin
    pending_d = (pending_q & ~pend_clr) | pend_retry | req_fold;
    mask_d    = cfg_interrupt_msi_mask_update ? cfg_interrupt_msi_data[IRQ_CNT-1:0] : mask_q;
    data_en_d = (pending_d != pending_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      mask_q      <= '0;
      rr_q        <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      msi_int_q   <= '0;
      stat_sent_q <= 1'b0;
      stat_fail_q <= 1'b0;
      data_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      rr_q        <= rr_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      msi_int_q   <= msi_int_d;
      stat_sent_q <= stat_sent_d;
      stat_fail_q <= stat_fail_d;
      data_en_q   <= data_en_d;
    end
  end

  assign cfg_interrupt_msi_select                      = 2'd0;
  assign cfg_interrupt_msi_int                         = msi_int_q;
  assign cfg_interrupt_msi_pending_status              = 32'(pending_q);
  assign cfg_interrupt_msi_pending_status_data_enable  = data_en_q;
  assign cfg_interrupt_msi_pending_status_function_num = 2'd0;
  assign stat_sent                                     = stat_sent_q;
  assign stat_fail                                     = stat_fail_q;

endmodule

// File: doc/cndm_msi_irq_ctrl.md
Name: cndm_msi_irq_ctrl

Overview:
- Schedules device interrupt requests onto the UltraScale PCIe hard IP MSI interface (cfg_interrupt_msi_*) for function 0.
- Collects per-vector requests from the NIC core (queue completion and event sources), applies the host MSI mask and multi-message enable, and round-robins among eligible vectors.
- Issues one MSI at a time, waits for sent or fail, and retries after a backoff.
- Sits between the core interrupt sources and the PCIe IP configuration interface in the PCIe top level.

Parameters:
IRQ_CNT, 32, number of interrupt vectors (1..32)
RETRY_DELAY, 16, idle cycles after fail or timeout before re-arbitration (>=1)
TIMEOUT, 1024, cycles to wait for sent/fail before treating an issue as failed

Ports:
clk  in  1  clock (PCIe user clock)
rst  in  1  synchronous active-high reset
irq_req  in  IRQ_CNT  per-vector request strobes; any bit high in a cycle sets that vector pending
cfg_interrupt_msi_enable  in  4  MSI enable per function; only bit 0 used
cfg_interrupt_msi_mmenable  in  12  multi-message enable; [2:0] used, nvec = 2^mmenable[2:0], clamped to IRQ_CNT
cfg_interrupt_msi_mask_update  in  1  strobe: mask register for the selected function is presented on cfg_interrupt_msi_data
cfg_interrupt_msi_data  in  32  MSI mask value, valid with mask_update
cfg_interrupt_msi_select  out  2  function select, constant 0
cfg_interrupt_msi_int  out  32  one-hot, one-cycle MSI issue
cfg_interrupt_msi_sent  in  1  IP sent the issued MSI
cfg_interrupt_msi_fail  in  1  IP failed the issued MSI
cfg_interrupt_msi_pending_status  out  32  pending vector bits reported to the IP
cfg_interrupt_msi_pending_status_data_enable  out  1  one-cycle strobe qualifying pending_status
cfg_interrupt_msi_pending_status_function_num  out  2  constant 0
stat_sent  out  1  one-cycle pulse per successful MSI
stat_fail  out  1  one-cycle pulse per fail or timeout

Behaviour:
- Reset:
  - pending, mask, round-robin pointer, counters = 0.
  - msi_int = 0, data_enable = 0, stat_* = 0; FSM in IDLE.
- Request folding: a request on vector v >= nvec sets pending bit (v mod nvec). Requests on bits >= IRQ_CNT are ignored.
- pending is registered. A request at cycle N is visible in pending at N+1.
- Mask: captured from msi_data[IRQ_CNT-1:0] on the cycle mask_update is high. Masked vectors stay pending and are never issued. Unmasking makes them eligible on the next arbitration.
- eligible = pending & ~mask & {IRQ_CNT{msi_enable[0]}}, restricted to v < nvec.
- FSM:
  - IDLE: if eligible != 0, pick the first eligible vector at or above (last_grant+1) modulo IRQ_CNT. Register msi_int = 1<<v for exactly one cycle, clear pending[v], record v, go to WAIT. Latency from irq_req to msi_int is 2 cycles when idle and unmasked.
  - WAIT: msi_int = 0; timeout counter runs.
    - sent -> stat_sent pulse, last_grant = v, go to IDLE.
    - fail, or counter reaching TIMEOUT -> re-set pending[v], stat_fail pulse, go to BACKOFF.
    - sent and fail in the same cycle: treated as sent.
  - BACKOFF: count RETRY_DELAY cycles, then go to IDLE. last_grant is not updated, so the failed vector is retried first.
- A request for the in-flight vector during WAIT or BACKOFF sets pending normally. One MSI then follows after the current one completes; duplicates merge.
- msi_enable[0] dropping during WAIT: the FSM still waits for sent/fail/timeout. Pending is retained; nothing is issued while disabled.
- pending_status = pending zero-extended to 32 bits. data_enable pulses for one cycle on the cycle after pending changes value.
- Simultaneous irq_req for vector v and issue of v: the issue clears the bit and the request sets it. The request wins, so the bit remains pending.

Test Plan:
- Single request: mmenable=5, mask=0, enable=1, irq_req[3] pulse at cycle 0 -> msi_int=0x8 at cycle 2; sent at cycle 5 -> stat_sent pulse, pending=0, data_enable strobes after set and after clear.
- Round-robin: irq_req = 0x15 in one cycle, each MSI sent 2 cycles after issue -> issue order vectors 0, 2, 4, with no MSI outstanding concurrently.
- Mask: mask_update with data=0x2, then irq_req[1] -> no msi_int and pending_status=0x2; mask_update with data=0 -> msi_int=0x2 two cycles later.
- Fail/retry: issue vector 7, assert fail -> stat_fail pulse, pending[7]=1, next msi_int=0x80 exactly RETRY_DELAY+1 cycles after fail. Timeout with neither sent nor fail behaves the same after TIMEOUT cycles.
- Folding and enable: mmenable=2 (nvec=4), irq_req[9] -> msi_int=0x2. With msi_enable=0, irq_req[0] stays pending with no issue until enable returns to 1.
- Reset mid-WAIT: rst during WAIT with pending=0xF0 -> all outputs 0 and pending 0 next cycle; a late sent after reset is ignored and no stat_sent pulses.
